// File: rtl/fetch_vectored.sv
// Instruction fetch stage with a vectored, masked, fixed-priority interrupt controller.
// Tracks PC and EPC, latches level requests, and redirects fetch to per-source vectors.
module fetch_vectored #(
    parameter int unsigned XLEN          = 32,
    parameter int unsigned NUM_IRQ       = 8,
    parameter logic [XLEN-1:0] RESET_ADDRESS = '0,
    parameter logic [XLEN-1:0] VECTOR_BASE   = 'h20,
    parameter int unsigned VECTOR_STRIDE = 4,
    parameter int unsigned EPC_ADJUST    = 3,
    localparam int unsigned IDW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               br_stall,
    input  logic [1:0]         pc_sel,
    input  logic [XLEN-1:0]    pc_branch,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [NUM_IRQ-1:0] irq_mask,
    input  logic               rti,
    output logic [XLEN-1:0]    pc,
    output logic [XLEN-1:0]    pc_plus_4,
    output logic [XLEN-1:0]    epc,
    output logic               int_take,
    output logic [IDW-1:0]     int_id,
    output logic               in_service,
    output logic               sr
);

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_SERVICE = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [XLEN-1:0]    pc_q, pc_d;
    logic [XLEN-1:0]    epc_q, epc_d;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [IDW-1:0]     int_id_q, int_id_d;

    logic [NUM_IRQ-1:0] eligible;
    logic [IDW-1:0]     sel;
    logic               take;
    logic               rti_done;
    logic [XLEN-1:0]    seq_pc;
    logic [XLEN-1:0]    mux_pc;
    logic [XLEN-1:0]    ret_pc;

    function automatic logic [XLEN-1:0] vec_addr(input logic [IDW-1:0] idx);
        return VECTOR_BASE + XLEN'(idx) * XLEN'(VECTOR_STRIDE);
    endfunction

    assign seq_pc   = pc_q + XLEN'(1);
    assign eligible = pending_q & ~irq_mask;

    // Scan downwards so the lowest eligible index wins.
    always_comb begin
        sel = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                sel = IDW'(i);
            end
        end
    end

    assign take = (state_q == ST_RUN) & (|eligible) & ~stall & ~br_stall & ~rti;
    assign rti_done = (state_q == ST_SERVICE) & rti & ~stall;

    assign ret_pc = (epc_q >= XLEN'(EPC_ADJUST)) ?
                    (epc_q - XLEN'(EPC_ADJUST)) : '0;

    always_comb begin
        mux_pc = RESET_ADDRESS;
        unique case (pc_sel)
            2'b00: mux_pc = RESET_ADDRESS;
            2'b01: mux_pc = (state_q == ST_SERVICE) ?
                            vec_addr(int_id_q) : vec_addr(sel);
            2'b10: mux_pc = seq_pc;
            2'b11: mux_pc = pc_branch;
            default: mux_pc = RESET_ADDRESS;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        epc_d     = epc_q;
        int_id_d  = int_id_q;
        pending_d = pending_q;

        // A new request in the same cycle beats the rti clear.
        if (rti_done) begin
            pending_d[int_id_q] = 1'b0;
        end
        pending_d = pending_d | irq;

        if (take) begin
            pc_d     = vec_addr(sel);
            epc_d    = seq_pc;
            int_id_d = sel;
            state_d  = ST_SERVICE;
        end else if (rti_done) begin
            pc_d    = ret_pc;
            state_d = ST_RUN;
        end else if (!stall) begin
            pc_d = mux_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_RUN;
            pc_q      <= RESET_ADDRESS;
            epc_q     <= '0;
            pending_q <= '0;
            int_id_q  <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            epc_q     <= epc_d;
            pending_q <= pending_d;
            int_id_q  <= int_id_d;
        end
    end

    assign pc         = pc_q;
    assign pc_plus_4  = seq_pc;
    assign epc        = epc_q;
    assign int_take   = take;
    assign int_id     = int_id_q;
    assign in_service = (state_q == ST_SERVICE);
    assign sr         = (state_q != ST_SERVICE);

endmodule
